// File: rtl/des_pkg.sv
// Shared DES datapath types used by the final permutation and the block serializer.
package des_pkg;

    localparam int DES_BLOCK_W = 64;

    typedef logic [DES_BLOCK_W-1:0] des_block_t;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_t;

    // Odd parity over a zero-padded beat; padding zeros do not change the result.
    function automatic logic odd_par(input logic [31:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/des_block_hold.sv
// Single-entry holding slot that parks the next ciphertext block while the serializer drains.
module des_block_hold
    import des_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       unload,
    input  des_block_t d_block,
    input  logic       d_last,
    output des_block_t q_block,
    output logic       q_last,
    output logic       full
);

    des_block_t block_r;
    logic       last_r;
    logic       full_r;

    // Slot storage; a load in the same cycle as an unload keeps the slot occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            block_r <= 64'd0;
            last_r  <= 1'b0;
            full_r  <= 1'b0;
        end else begin
            if (load) begin
                block_r <= d_block;
                last_r  <= d_last;
            end
            if (load) begin
                full_r <= 1'b1;
            end else if (unload) begin
                full_r <= 1'b0;
            end
        end
    end

    assign q_block = block_r;
    assign q_last  = last_r;
    assign full    = full_r;

endmodule

// File: rtl/des_block_serializer.sv
// Splits 64-bit DES blocks into OUT_W-bit beats with a one-block holding slot for gapless streaming.
// Optional DES_SER_PARITY_EN adds a registered odd-parity bit out_par alongside out_data.
module des_block_serializer
    import des_pkg::*;
#(
    parameter int OUT_W     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      in_block,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
`ifdef DES_SER_PARITY_EN
    output logic             out_par,
`endif
    input  logic             out_ready
);

    localparam int BEATS = DES_BLOCK_W / OUT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    ser_state_t       state_r, state_s;
    des_block_t       sh_r, sh_s, sh_shift_s;
    logic             sh_last_r, sh_last_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;

    des_block_t hold_block_s;
    logic       hold_last_s;
    logic       hold_full_s;
    logic       hold_load_s;
    logic       hold_unload_s;

    logic accept_s;
    logic beat_s;
    logic final_s;

    function automatic logic [OUT_W-1:0] beat_of(input des_block_t b);
        if (MSB_FIRST) begin
            return b[DES_BLOCK_W-1 -: OUT_W];
        end else begin
            return b[OUT_W-1:0];
        end
    endfunction

    des_block_hold u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (hold_load_s),
        .unload  (hold_unload_s),
        .d_block (in_block),
        .d_last  (in_last),
        .q_block (hold_block_s),
        .q_last  (hold_last_s),
        .full    (hold_full_s)
    );

    // Next-state logic: direct load, hold load, shift and hold-to-shifter transfer.
    always_comb begin
        state_s       = state_r;
        sh_s          = sh_r;
        sh_last_s     = sh_last_r;
        cnt_s         = cnt_r;
        hold_load_s   = 1'b0;
        hold_unload_s = 1'b0;
        accept_s      = in_valid && !hold_full_s;
        beat_s        = (state_r == SER_SEND) && out_ready;
        final_s       = beat_s && (cnt_r == CNT_LAST);
        if (MSB_FIRST) begin
            sh_shift_s = sh_r << OUT_W;
        end else begin
            sh_shift_s = sh_r >> OUT_W;
        end
        case (state_r)
            SER_IDLE: begin
                if (accept_s) begin
                    sh_s      = in_block;
                    sh_last_s = in_last;
                    cnt_s     = {CNT_W{1'b0}};
                    state_s   = SER_SEND;
                end else begin
                    state_s = SER_IDLE;
                end
            end
            SER_SEND: begin
                if (final_s) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (hold_full_s) begin
                        sh_s          = hold_block_s;
                        sh_last_s     = hold_last_s;
                        hold_unload_s = 1'b1;
                        hold_load_s   = accept_s;
                    end else if (accept_s) begin
                        sh_s      = in_block;
                        sh_last_s = in_last;
                    end else begin
                        sh_s      = sh_shift_s;
                        sh_last_s = 1'b0;
                        state_s   = SER_IDLE;
                    end
                end else if (beat_s) begin
                    sh_s        = sh_shift_s;
                    cnt_s       = cnt_r + CNT_W'(1);
                    hold_load_s = accept_s;
                end else begin
                    hold_load_s = accept_s;
                end
            end
            default: begin
                state_s   = SER_IDLE;
                sh_s      = 64'd0;
                sh_last_s = 1'b0;
                cnt_s     = {CNT_W{1'b0}};
            end
        endcase
    end

    // Shifter, beat counter and state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= SER_IDLE;
            sh_r      <= 64'd0;
            sh_last_r <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_s;
            sh_r      <= sh_s;
            sh_last_r <= sh_last_s;
            cnt_r     <= cnt_s;
        end
    end

`ifdef DES_SER_PARITY_EN
    logic par_r;

    // Parity is computed from the next beat so it lands in the same cycle as out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_r <= 1'b1;
        end else begin
            par_r <= odd_par(32'(beat_of(sh_s)));
        end
    end

    assign out_par = par_r;
`endif

    assign in_ready  = !hold_full_s;
    assign out_valid = (state_r == SER_SEND);
    assign out_data  = beat_of(sh_r);
    assign out_last  = out_valid && sh_last_r && (cnt_r == CNT_LAST);

endmodule
